// File: rtl/icache_dm.sv
// icache_dm: direct-mapped read-only instruction cache with whole-line refill from a handshaked backing memory
module icache_dm #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] instr,
  output logic        stall,
  input  logic        inv,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  localparam int WB  = $clog2(WORDS);
  localparam int OFF = WB + 2;
  localparam int IDX = $clog2(LINES);
  localparam int TAG = 32 - IDX - OFF;
  typedef enum logic {IDLE, REFILL} state_t;
  state_t           state;
  logic [LINES-1:0] valid;
  logic [TAG-1:0]   tags [LINES];
  logic [31:0]      data [LINES*WORDS];
  logic [IDX-1:0]   idx, ridx;
  logic [WB-1:0]    off, cnt;
  logic [TAG-1:0]   ptag;
  logic             kill, hit, last, unused;
  assign off    = pc[OFF-1:2];
  assign idx    = pc[OFF+IDX-1:OFF];
  assign ptag   = pc[31:OFF+IDX];
  assign unused = ^pc[1:0];
  assign hit    = state == IDLE && valid[idx] && tags[idx] == ptag && !reset && !inv;
  assign instr  = hit ? data[{idx, off}] : '0;
  assign stall  = !reset && !hit;
  assign last   = state == REFILL && mem_ack && cnt == WB'(WORDS - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      valid    <= '0;
      cnt      <= '0;
      kill     <= 1'b0;
      ridx     <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else if (state == IDLE) begin
      if (inv) valid <= '0;
      else if (!hit) begin
        state    <= REFILL;
        ridx     <= idx;
        cnt      <= '0;
        mem_req  <= 1'b1;
        mem_addr <= {pc[31:OFF], OFF'(0)};
      end
    end else begin
      if (inv) begin
        valid <= '0;
        kill  <= 1'b1;
      end
      if (mem_ack) begin
        cnt      <= cnt + 1'b1;
        mem_addr <= mem_addr + 32'd4;
        if (last) begin
          state   <= IDLE;
          mem_req <= 1'b0;
          kill    <= 1'b0;
          if (!kill && !inv) valid[ridx] <= 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && state == REFILL && mem_ack) data[{ridx, cnt}] <= mem_rdata;
    if (!reset && last) tags[ridx] <= mem_addr[31:OFF+IDX];
  end
endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: scoreboard bench for icache_dm against a memory model returning addr+0x100
module tb_icache_dm;
  logic        clk = 0, reset = 1, inv = 0, mem_ack = 0;
  logic [31:0] pc = 0, mem_rdata = 0;
  logic [31:0] instr, mem_addr;
  logic        stall, mem_req;
  int          n_chk = 0, n_fail = 0, wait_n = 0, wcnt = 0, acks = 0;
  bit          hold = 0;
  logic [31:0] exp_addr [$];
  logic [31:0] exp_instr [$];
  icache_dm dut (
    .clk(clk), .reset(reset), .pc(pc), .instr(instr), .stall(stall), .inv(inv),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (mem_req && !hold) begin
      if (wcnt == wait_n) begin
        mem_ack   = 1;
        mem_rdata = mem_addr + 32'h100;
        wcnt      = 0;
        acks++;
        if (exp_addr.size() > 0) check("mem_addr", mem_addr, exp_addr.pop_front());
        else check("unexpected_req", 32'(exp_addr.size()), 32'd1);
      end else begin
        mem_ack = 0;
        wcnt++;
        if (exp_addr.size() > 0) check("mem_addr_wait", mem_addr, exp_addr[0]);
      end
    end else begin
      mem_ack = 0;
      wcnt    = 0;
    end
  end
  task automatic push_line(input logic [31:0] a);
    for (int i = 0; i < 4; i++) exp_addr.push_back((a & ~32'hF) + 32'(4 * i));
  endtask
  task automatic fetch(input logic [31:0] a, input int exp_stall);
    int n = 0;
    if (exp_stall > 0) push_line(a);
    exp_instr.push_back(a + 32'h100);
    pc = a;
    #1;
    while (stall && n < 200) begin
      n++;
      @(negedge clk);
      #1;
    end
    check("instr", instr, exp_instr.pop_front());
    check("stall_cycles", 32'(n), 32'(exp_stall));
    @(negedge clk);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    int n, a0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_stall", 32'(stall), 0);
    check("rst_req", 32'(mem_req), 0);
    check("rst_addr", mem_addr, 0);
    check("rst_instr", instr, 0);
    @(negedge clk);
    reset = 0;
    fetch(32'h00, 5);
    for (int i = 1; i < 4; i++) begin
      fetch(32'(4 * i), 0);
      check("hit_req", 32'(mem_req), 0);
    end
    fetch(32'h100, 5);
    fetch(32'h000, 5);
    wait_n = 2;
    fetch(32'h40, 13);
    wait_n = 0;
    fetch(32'h44, 0);
    inv = 1;
    pc  = 32'h00;
    #1;
    check("inv_stall", 32'(stall), 1);
    check("inv_instr", instr, 0);
    @(negedge clk);
    inv = 0;
    fetch(32'h00, 5);
    push_line(32'h40);
    push_line(32'h40);
    exp_instr.push_back(32'h140);
    pc = 32'h40;
    n  = 1;
    @(negedge clk);
    #1;
    inv = 1;
    @(negedge clk);
    #1;
    inv = 0;
    n += 1;
    while (stall && n < 200) begin
      n++;
      @(negedge clk);
      #1;
    end
    check("kill_instr", instr, exp_instr.pop_front());
    check("kill_stall_cycles", 32'(n), 10);
    @(negedge clk);
    a0 = acks;
    exp_addr.push_back(32'h80);
    exp_addr.push_back(32'h84);
    pc = 32'h80;
    n  = 0;
    while (acks < a0 + 2 && n < 50) begin
      n++;
      @(negedge clk);
      #1;
    end
    check("rst_mid_acks", 32'(acks - a0), 2);
    hold = 1;
    @(negedge clk);
    #1;
    reset = 1;
    #1;
    check("rst_mid_stall", 32'(stall), 0);
    @(negedge clk);
    #1;
    check("rst_mid_req", 32'(mem_req), 0);
    reset = 0;
    hold  = 0;
    fetch(32'h80, 5);
    fetch(32'h8C, 0);
    check("addr_left", 32'(exp_addr.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
